// File: rtl/counter_arbiter.sv
// Round-robin arbiter that time-shares one downstream counter among clients.
// Each grant clears the counter, enables it for a slot, then pulses done.
module counter_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_COUNT = 8,
    localparam int CW = $clog2(MAX_COUNT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic               cnt_rst,
    output logic               cnt_enable,
    output logic [CW-1:0]      slot_cnt,
    output logic               busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CW-1:0]      LAST    = CW'(MAX_COUNT - 1);
    localparam logic [NUM_REQ-1:0] ONE     = NUM_REQ'(1);
    localparam logic [IW-1:0]      PTR_RST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;

    logic               pick_vld;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      cand;

    // Walk from the farthest slot back to ptr+1 so the nearest requester wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IW'((int'(ptr_q) + i) % NUM_REQ);
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                // Terminal count and a dropped request both end the slot normally.
                if (cnt_q == LAST || !req[owner_q]) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                ptr_d   = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_d  = '0;
        done_d = '0;
        if (state_d == CLEAR || state_d == RUN) begin
            gnt_d = ONE << owner_d;
        end
        if (state_d == RELEASE) begin
            done_d = ONE << owner_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= PTR_RST;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    // The counter stays cleared for as long as this block is in reset.
    assign cnt_rst    = rst | (state_q == CLEAR);
    assign cnt_enable = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign gnt        = gnt_q;
    assign done       = done_q;
    assign slot_cnt   = cnt_q;

    a_gnt_onehot: assert property (
        @(posedge clk) disable iff (rst) $onehot0(gnt_q)
    );

    a_cnt_bound: assert property (
        @(posedge clk) disable iff (rst)
        (state_q == RUN) |-> (cnt_q <= LAST)
    );

endmodule
